// File: rtl/updown_count_scheduler.sv
// Two requesters share one wrap-around up/down counter through a round-robin arbiter.
// An accepted command steps the counter once per cycle, then pulses done to its owner.
module updown_count_scheduler #(
    parameter int N     = 4,
    parameter int TOP   = 15,
    parameter int STEPW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req0_dir,
    input  logic [STEPW-1:0] req0_steps,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_dir,
    input  logic [STEPW-1:0] req1_steps,
    output logic             req1_ready,
    output logic [N-1:0]     count,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic             done_id,
    output logic             wrap
);

    // state | meaning
    // IDLE  | waiting for a command; arbiter drives the ready outputs
    // RUN   | stepping count once per cycle until remaining runs out
    // DONE  | one-cycle completion pulse to the owning requester
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] TOP_V = N'(TOP);

    state_t           state;
    logic             last_grant;
    logic             dir_q;
    logic [STEPW-1:0] remaining;

    logic             grant0;
    logic             grant1;
    logic             acc_id;
    logic             acc_dir;
    logic [STEPW-1:0] acc_steps;
    logic [N-1:0]     count_next;
    logic             wrap_next;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    always_comb begin
        acc_id    = req1_ready;
        acc_dir   = req1_ready ? req1_dir   : req0_dir;
        acc_steps = req1_ready ? req1_steps : req0_steps;
    end

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (dir_q) begin
            if (count == TOP_V) begin
                count_next = '0;
                wrap_next  = 1'b1;
            end else begin
                count_next = count + N'(1);
            end
        end else begin
            if (count == '0) begin
                count_next = TOP_V;
                wrap_next  = 1'b1;
            end else begin
                count_next = count - N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            wrap       <= 1'b0;
            last_grant <= 1'b1;
            dir_q      <= 1'b0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner      <= acc_id;
                        last_grant <= acc_id;
                        dir_q      <= acc_dir;
                        remaining  <= acc_steps;
                        busy       <= 1'b1;
                        if (acc_steps == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            done_id <= acc_id;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    count     <= count_next;
                    wrap      <= wrap_next;
                    remaining <= remaining - STEPW'(1);
                    if (remaining == STEPW'(1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        done_id <= owner;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_count_scheduler.sv
// Bench for updown_count_scheduler: directed scenarios plus random commands
// checked against a transaction-level model of the shared counter.
module tb_updown_count_scheduler;
    localparam int N     = 4;
    localparam int TOP   = 15;
    localparam int STEPW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid;
    logic             req0_dir;
    logic [STEPW-1:0] req0_steps;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_dir;
    logic [STEPW-1:0] req1_steps;
    logic             req1_ready;
    logic [N-1:0]     count;
    logic             busy;
    logic             owner;
    logic             done;
    logic             done_id;
    logic             wrap;

    int n_cmp = 0;
    int n_err = 0;
    int m_count = 0;
    int m_last = 1;
    bit m_wrap = 1'b0;

    updown_count_scheduler #(.N(N), .TOP(TOP), .STEPW(STEPW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_steps(req0_steps), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_steps(req1_steps), .req1_ready(req1_ready),
        .count(count), .busy(busy), .owner(owner), .done(done), .done_id(done_id), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit v0, input bit d0, input int s0,
                           input bit v1, input bit d1, input int s1);
        req0_valid = v0; req0_dir = d0; req0_steps = STEPW'(s0);
        req1_valid = v1; req1_dir = d1; req1_steps = STEPW'(s1);
    endtask

    // Called in an IDLE cycle with the requests already driven; runs one whole command.
    task automatic exec_cmd(input bit drop);
        int waitc;
        int g;
        int s;
        bit d;
        waitc = 0;
        #1;
        while (!(req0_ready || req1_ready) && waitc < 20) begin
            tick();
            #1;
            waitc++;
        end
        chk("accept_wait", waitc, 0);
        if (waitc >= 20) return;
        g = (req0_valid && req1_valid) ? (m_last == 1 ? 0 : 1) : (req0_valid ? 0 : 1);
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("idle_busy", busy, 0);
        d = g ? req1_dir : req0_dir;
        s = g ? int'(req1_steps) : int'(req0_steps);
        tick();
        m_last = g;
        m_wrap = 1'b0;
        if (drop) begin
            if (g == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
        end
        for (int i = 0; i < s; i++) begin
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_ready", {req0_ready, req1_ready}, 0);
            chk("run_count", count, m_count);
            chk("run_wrap", wrap, m_wrap);
            tick();
            if (d) m_count = (m_count + 1) % (TOP + 1);
            else   m_count = (m_count + TOP) % (TOP + 1);
            m_wrap = d ? (m_count == 0) : (m_count == TOP);
        end
        chk("done_pulse", done, 1);
        chk("done_id", done_id, g);
        chk("done_owner", owner, g);
        chk("done_busy", busy, 1);
        chk("done_count", count, m_count);
        chk("done_wrap", wrap, m_wrap);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy_after", busy, 0);
        chk("idle_wrap", wrap, 0);
        chk("idle_count", count, m_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);

        // up 3 from zero, then back down to zero
        set_req(1, 1, 3, 0, 0, 0);
        exec_cmd(1);
        chk("up3_count", count, 3);
        set_req(1, 0, 3, 0, 0, 0);
        exec_cmd(1);

        // req1 down 2 through the 0->TOP wrap
        set_req(0, 0, 0, 1, 0, 2);
        exec_cmd(1);
        chk("down2_count", count, 14);

        // both requesters held: grants alternate 0,1,0
        set_req(1, 1, 1, 1, 1, 1);
        exec_cmd(0);
        chk("tie1_owner", owner, 0);
        exec_cmd(0);
        chk("tie2_owner", owner, 1);
        exec_cmd(1);
        chk("tie3_owner", owner, 0);
        set_req(0, 0, 0, 0, 0, 0);
        tick();

        // zero-step command
        set_req(1, 1, 0, 0, 0, 0);
        exec_cmd(1);

        // reset in the middle of a long command
        set_req(1, 1, 8, 0, 0, 0);
        #1;
        chk("abort_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_mid_count", count, (m_count + 3) % (TOP + 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_count = 0;
        m_last = 1;
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wrap", wrap, 0);
        tick();
        chk("abort_no_done", done, 0);
        set_req(1, 0, 1, 1, 0, 1);
        exec_cmd(1);
        chk("abort_tie_owner", owner, 0);
        chk("abort_tie_count", count, TOP);

        // TOP -> 0 wrap going up
        set_req(1, 1, 1, 0, 0, 0);
        exec_cmd(1);
        chk("upwrap_count", count, 0);

        for (int k = 0; k < 40; k++) begin
            bit v0;
            bit v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            set_req(v0, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                    v1, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
            exec_cmd(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
